// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
// Default IO port map and the handshake FSM state encoding.
package intc_pkg;

    localparam int ID_W = 3;

    localparam logic [7:0] INTC_MASK_PORT = 8'h30;
    localparam logic [7:0] INTC_PEND_PORT = 8'h31;
    localparam logic [7:0] INTC_ID_PORT   = 8'h32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; purely combinational, no latency.
// No backpressure; valid is simply the OR of the request vector.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        idx = '0;
        // Scan from the top so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/intc_ctrl.sv
// Interrupt controller: edge capture into pending, mask, fixed priority, INT_R/ACK/DONE handshake.
// Request is raised one edge after an eligible pending bit appears; registers on the MCU IO port bus.
module intc_ctrl
    import intc_pkg::*;
#(
    parameter int         NUM_SRC     = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MASK_PORT   = INTC_MASK_PORT,
    parameter logic [7:0] PEND_PORT   = INTC_PEND_PORT,
    parameter logic [7:0] ID_PORT     = INTC_ID_PORT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    input  logic               INT_EN,
    input  logic               INT_ACK,
    input  logic               INT_DONE,
    output logic               INT_R,
    output logic [ID_W-1:0]    INT_ID,
    output logic               IN_SERVICE,
    output logic [7:0]         IN_PORT_DATA,
    output logic               IN_PORT_SEL
);

    logic [NUM_SRC-1:0] sync_lvl;
    logic [NUM_SRC-1:0] prev_lvl;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] eligible;
    logic               elig_vld;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    int_id_nxt;
    intc_state_t        state;
    intc_state_t        state_nxt;
    logic               wr_mask;
    logic               wr_pend;
    logic               ack_fire;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_lvl = IRQ_IN;
        end else begin : g_sync
            logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= IRQ_IN;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end
            assign sync_lvl = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign rise     = sync_lvl & ~prev_lvl;
    assign eligible = pending & mask;
    assign wr_mask  = IO_STRB && (PORT_ID == MASK_PORT);
    assign wr_pend  = IO_STRB && (PORT_ID == PEND_PORT);
    assign ack_fire = (state == REQ) && INT_ACK;

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req   (eligible),
        .valid (elig_vld),
        .idx   (winner)
    );

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ack_fire && (INT_ID == ID_W'(i))) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // Clears are applied first so a same-cycle rising edge always survives.
    always_comb begin
        pending_nxt = pending & ~ack_clr;
        if (wr_pend) begin
            pending_nxt = pending_nxt & ~OUT_PORT[NUM_SRC-1:0];
        end
        pending_nxt = pending_nxt | rise;
    end

    always_comb begin
        state_nxt  = state;
        int_id_nxt = INT_ID;
        case (state)
            IDLE: begin
                if (INT_EN && elig_vld) begin
                    state_nxt  = REQ;
                    int_id_nxt = winner;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    state_nxt = SERVICE;
                end else if (!elig_vld || !INT_EN) begin
                    state_nxt = IDLE;
                end else begin
                    int_id_nxt = winner;
                end
            end
            SERVICE: begin
                if (INT_DONE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_lvl <= '0;
            mask     <= '0;
            pending  <= '0;
            state    <= IDLE;
            INT_ID   <= '0;
        end else begin
            prev_lvl <= sync_lvl;
            pending  <= pending_nxt;
            state    <= state_nxt;
            INT_ID   <= int_id_nxt;
            if (wr_mask) begin
                mask <= OUT_PORT[NUM_SRC-1:0];
            end
        end
    end

    assign INT_R      = (state == REQ);
    assign IN_SERVICE = (state == SERVICE);

    always_comb begin
        IN_PORT_DATA = 8'h00;
        IN_PORT_SEL  = 1'b0;
        if (PORT_ID == MASK_PORT) begin
            IN_PORT_DATA = 8'(mask);
            IN_PORT_SEL  = 1'b1;
        end else if (PORT_ID == PEND_PORT) begin
            IN_PORT_DATA = 8'(pending);
            IN_PORT_SEL  = 1'b1;
        end else if (PORT_ID == ID_PORT) begin
            IN_PORT_DATA = {IN_SERVICE, INT_R, 3'b000, INT_ID};
            IN_PORT_SEL  = 1'b1;
        end
    end

endmodule

// File: tb/tb_intc_ctrl.sv
// Directed bench for intc_ctrl: edge capture, priority, handshake, W1C and reset.
module tb_intc_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IRQ_IN;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic       INT_EN;
    logic       INT_ACK;
    logic       INT_DONE;
    logic       INT_R;
    logic [2:0] INT_ID;
    logic       IN_SERVICE;
    logic [7:0] IN_PORT_DATA;
    logic       IN_PORT_SEL;

    int n_tests = 0;
    int n_fail  = 0;

    intc_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IRQ_IN       (IRQ_IN),
        .PORT_ID      (PORT_ID),
        .OUT_PORT     (OUT_PORT),
        .IO_STRB      (IO_STRB),
        .INT_EN       (INT_EN),
        .INT_ACK      (INT_ACK),
        .INT_DONE     (INT_DONE),
        .INT_R        (INT_R),
        .INT_ID       (INT_ID),
        .IN_SERVICE   (IN_SERVICE),
        .IN_PORT_DATA (IN_PORT_DATA),
        .IN_PORT_SEL  (IN_PORT_SEL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic [7:0] port, input logic [7:0] exp);
        PORT_ID = port;
        #1;
        chk(tag, IN_PORT_DATA, exp);
        PORT_ID = 8'h00;
    endtask

    task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
        PORT_ID  = port;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    task automatic done();
        INT_DONE = 1'b1;
        tick();
        INT_DONE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; IRQ_IN = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00;
        IO_STRB = 1'b0; INT_EN = 1'b1; INT_ACK = 1'b0; INT_DONE = 1'b0;
        ticks(2);
        RESET = 1'b0;
        chk("rst_int_r", {7'b0, INT_R}, 8'h00);
        chk("rst_in_service", {7'b0, IN_SERVICE}, 8'h00);
        chk_port("rst_mask", 8'h30, 8'h00);
        chk_port("rst_id_port", 8'h32, 8'h00);

        // 1: basic request / ack / done on source 3
        io_wr(8'h30, 8'hFF);
        IRQ_IN = 8'h08;
        ticks(2);
        chk_port("t1_pend_k1", 8'h31, 8'h00);
        tick();
        chk_port("t1_pend_k2", 8'h31, 8'h08);
        chk("t1_int_r_k2", {7'b0, INT_R}, 8'h00);
        tick();
        chk("t1_int_r_k3", {7'b0, INT_R}, 8'h01);
        chk("t1_int_id", {5'b0, INT_ID}, 8'h03);
        ack();
        chk_port("t1_pend_ack", 8'h31, 8'h00);
        chk("t1_in_service", {7'b0, IN_SERVICE}, 8'h01);
        chk("t1_int_r_ack", {7'b0, INT_R}, 8'h00);
        done();
        chk("t1_done", {7'b0, IN_SERVICE}, 8'h00);
        IRQ_IN = 8'h00;
        ticks(3);

        // 2: simultaneous arrivals, one masked
        io_wr(8'h30, 8'h04);
        IRQ_IN = 8'h24;
        ticks(3);
        chk_port("t2_pend", 8'h31, 8'h24);
        tick();
        chk("t2_int_r", {7'b0, INT_R}, 8'h01);
        chk("t2_int_id", {5'b0, INT_ID}, 8'h02);
        ack();
        chk_port("t2_pend_ack", 8'h31, 8'h20);
        ticks(2);
        chk("t2_no_req_masked", {7'b0, INT_R}, 8'h00);
        io_wr(8'h30, 8'hFF);
        done();
        chk("t2_idle_after_done", {7'b0, INT_R}, 8'h00);
        tick();
        chk("t2_rereq", {7'b0, INT_R}, 8'h01);
        chk("t2_rereq_id", {5'b0, INT_ID}, 8'h05);
        ack();
        done();
        IRQ_IN = 8'h00;
        ticks(3);

        // 3: higher-priority preemption before ack
        IRQ_IN = 8'h10;
        ticks(4);
        chk("t3_id4", {5'b0, INT_ID}, 8'h04);
        IRQ_IN = 8'h12;
        ticks(3);
        chk_port("t3_pend", 8'h31, 8'h12);
        tick();
        chk("t3_preempt_id", {5'b0, INT_ID}, 8'h01);
        chk("t3_still_req", {7'b0, INT_R}, 8'h01);
        ack();
        chk_port("t3_pend_ack", 8'h31, 8'h10);
        chk("t3_frozen_id", {5'b0, INT_ID}, 8'h01);
        done();
        tick();
        chk("t3_back_to_4", {5'b0, INT_ID}, 8'h04);

        // 4: W1C withdrawal, then W1C colliding with a new edge on bit 6
        io_wr(8'h31, 8'hFF);
        chk_port("t4_pend_clr", 8'h31, 8'h00);
        tick();
        chk("t4_withdrawn", {7'b0, INT_R}, 8'h00);
        chk("t4_id_held", {5'b0, INT_ID}, 8'h04);
        IRQ_IN = 8'h02;
        ticks(3);
        IRQ_IN = 8'h10;
        ticks(4);
        chk("t4_req4", {7'b0, INT_R}, 8'h01);
        IRQ_IN = 8'h50;
        ticks(2);
        io_wr(8'h31, 8'hFF);
        chk_port("t4_set_wins", 8'h31, 8'h40);
        tick();
        chk("t4_rereq", {7'b0, INT_R}, 8'h01);
        chk("t4_rereq_id", {5'b0, INT_ID}, 8'h06);
        ack();
        done();
        IRQ_IN = 8'h00;
        ticks(3);

        // 5: global enable gating
        INT_EN = 1'b0;
        IRQ_IN = 8'h01;
        ticks(3);
        chk_port("t5_pend", 8'h31, 8'h01);
        tick();
        chk("t5_gated", {7'b0, INT_R}, 8'h00);
        INT_EN = 1'b1;
        ticks(2);
        chk("t5_enabled", {7'b0, INT_R}, 8'h01);
        PORT_ID = 8'h32;
        #1;
        chk("t5_sel", {7'b0, IN_PORT_SEL}, 8'h01);
        chk("t5_id_port", IN_PORT_DATA, 8'h40);
        PORT_ID = 8'h00;

        // 6: reset while servicing
        ack();
        chk("t6_in_service", {7'b0, IN_SERVICE}, 8'h01);
        chk_port("t6_id_port_svc", 8'h32, 8'h80);
        IRQ_IN = 8'h81;
        ticks(3);
        chk_port("t6_pend_svc", 8'h31, 8'h80);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t6_in_service_rst", {7'b0, IN_SERVICE}, 8'h00);
        chk("t6_int_r_rst", {7'b0, INT_R}, 8'h00);
        chk_port("t6_mask_rst", 8'h30, 8'h00);
        chk_port("t6_pend_rst", 8'h31, 8'h00);
        PORT_ID = 8'h20;
        #1;
        chk("t6_sel_other", {7'b0, IN_PORT_SEL}, 8'h00);
        chk("t6_data_other", IN_PORT_DATA, 8'h00);
        PORT_ID = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intc_ctrl.md
Name: intc_ctrl

Overview:
Interrupt controller for the MCU. It collects up to NUM_SRC peripheral interrupt lines, latches rising edges into pending bits and applies a mask. It arbitrates by fixed priority and runs the INT_R / INT_ACK / INT_DONE handshake with the control unit. Mask, pending and ID registers are mapped onto the existing IO port bus (PORT_ID, OUT_PORT, IO_STRB, IN_PORT).

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8); index 0 is the highest priority.
SYNC_STAGES, 2, synchronizer flops per IRQ_IN line (0..3; 0 = no synchronizer).
MASK_PORT, 8'h30, port ID of the mask register (read/write).
PEND_PORT, 8'h31, port ID of the pending register (read; write-1-to-clear).
ID_PORT, 8'h32, port ID of the status register (read-only).

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active-high
IRQ_IN  in  NUM_SRC  peripheral interrupt levels
PORT_ID  in  8  IO port address from the MCU
OUT_PORT  in  8  IO write data from the MCU
IO_STRB  in  1  IO write strobe, one cycle
INT_EN  in  1  global interrupt enable from the control unit (SEI/CLI flag)
INT_ACK  in  1  control unit has entered the interrupt cycle, one-cycle pulse
INT_DONE  in  1  RETIE executed, one-cycle pulse
INT_R  out  1  interrupt request to the control unit
INT_ID  out  3  index of the request being presented or serviced
IN_SERVICE  out  1  a handler is active
IN_PORT_DATA  out  8  read data for the MCU input mux
IN_PORT_SEL  out  1  PORT_ID hits one of this block's ports

Behaviour:
- Reset (synchronous, checked at the CLK edge):
  - mask, pending, sync flops and previous-level flops = 0.
  - state = IDLE; INT_R = 0, INT_ID = 0, IN_SERVICE = 0.
- Edge capture:
  - Each IRQ_IN bit passes through SYNC_STAGES flops, then a previous-level flop.
  - A 0->1 on the synchronized level sets pending[i] on that edge.
  - With SYNC_STAGES=2, IRQ_IN high before edge k sets pending at edge k+2.
  - A level held high sets pending only once.
- Eligible vector = pending & mask. Winner = lowest set index, from a combinational priority encoder.
- Register writes (IO_STRB=1):
  - PORT_ID==MASK_PORT: mask <= OUT_PORT[NUM_SRC-1:0].
  - PORT_ID==PEND_PORT: pending <= pending & ~OUT_PORT.
  - Any other port ID is ignored.
- Clear/set conflicts on the same bit in the same cycle (new edge vs W1C clear, or new edge vs ack clear): the set wins.
- FSM states: IDLE, REQ, SERVICE. INT_R is registered and equals (state==REQ).
  - IDLE -> REQ when INT_EN=1 and eligible!=0. INT_ID <= winner. INT_R goes high at the following edge, i.e. edge k+3 in the example above.
  - REQ:
    - INT_ID tracks the current winner every cycle, so a higher-priority arrival preempts before ack.
    - If eligible becomes 0 (masked or W1C-cleared) or INT_EN=0 -> IDLE. INT_R drops and INT_ID is held.
    - If INT_ACK=1 -> SERVICE. pending[INT_ID] is cleared, INT_ID is frozen, IN_SERVICE=1.
    - INT_ACK takes precedence over a same-cycle withdrawal.
  - SERVICE:
    - INT_R=0; no nesting.
    - New edges still set pending bits.
    - INT_DONE=1 -> IDLE and IN_SERVICE=0. The earliest re-request is the edge after that.
- INT_ACK outside REQ and INT_DONE outside SERVICE are ignored.
- A RESET during REQ or SERVICE returns to IDLE at once, drops INT_R and IN_SERVICE, and clears pending.
- Read mux (combinational from PORT_ID):
  - MASK_PORT: IN_PORT_DATA = zero-extended mask.
  - PEND_PORT: IN_PORT_DATA = zero-extended pending.
  - ID_PORT: IN_PORT_DATA = {IN_SERVICE, INT_R, 3'b0, INT_ID}.
  - IN_PORT_SEL=1 only for these three ports; otherwise IN_PORT_DATA=0.
- Unused bits (index >= NUM_SRC) read 0 and are never set.

Decomposition:
- Package intc_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, SERVICE} intc_state_t.
  - Default port ID constants INTC_MASK_PORT, INTC_PEND_PORT, INTC_ID_PORT.
  - Localparam ID_W=3.
- Sub-module intc_prio_enc: combinational, NUM_SRC-wide; outputs a valid flag and a 3-bit lowest-set index. The edge capture, FSM and IO decode stay in intc_ctrl.

Test Plan:
1. Reset, write 8'h30<=8'hFF, raise IRQ_IN[3] -> pending=8'h08 at edge k+2, INT_R=1 at edge k+3, INT_ID=3; INT_ACK -> pending=0, IN_SERVICE=1, INT_R=0; INT_DONE -> IN_SERVICE=0.
2. Mask 8'h04, raise IRQ_IN[2] and IRQ_IN[5] together -> INT_ID=2, pending=8'h24. After ack, pending=8'h20 and no request while masked. Write mask 8'hFF then INT_DONE -> INT_R=1 with INT_ID=5.
3. In REQ with INT_ID=4, raise IRQ_IN[1] before ack -> INT_ID changes to 1; ack clears bit 1 only, pending keeps 8'h10.
4. In REQ, write 8'h31<=OUT_PORT 8'hFF -> pending=0, FSM to IDLE, INT_R=0 next edge. Repeat with a same-cycle new edge on bit 6 -> pending=8'h40 and the request is re-raised.
5. INT_EN=0 with pending=8'h01 -> INT_R stays 0. Set INT_EN=1 -> INT_R=1 two edges later. Read PORT_ID 8'h32 -> IN_PORT_SEL=1, data=8'h40.
6. Assert RESET in SERVICE -> next edge IN_SERVICE=0, INT_R=0, mask=0, pending=0. Reading PORT_ID 8'h20 -> IN_PORT_SEL=0, data=0.
